cbfp_blk_window: RTL and testbench

Multi-lane, valid-qualified complex window register for the CBFP stage of the FFT pipeline. It collects DEPTH valid beats of LANES parallel I/Q samples into one block. Alongside the data it computes the block's common normalization shift, which is the minimum count of redundant sign bits across every sample in the block. When a block completes, the block and its shift are presented together for one cycle, ready for the CBFP scaler.

---
 rtl/cbfp_pkg.sv | 26 ++
 rtl/cbfp_rsb_cnt.sv | 35 +++
 rtl/cbfp_blk_window.sv | 164 ++++++++++++++++
 tb/tb_cbfp_blk_window.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// cbfp_pkg
//   Shared types and width helpers for the CBFP block window.
//   - state_t       : block-collection FSM state (EMPTY / FILL)
//   - shift_width() : width of a redundant-sign-bit count for a given sample width
//   - cnt_width()   : width of a beat counter able to hold 0..depth
//   - shift_max()   : largest possible redundant-sign-bit count (sample width - 1)
package cbfp_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } state_t;

  function automatic int shift_width(input int data_width);
    return $clog2(data_width);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int shift_max(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/cbfp_rsb_cnt.sv
// cbfp_rsb_cnt
//   Combinational redundant-sign-bit counter for one signed sample.
//   Counts the leading bits equal to the MSB, minus one, so the result
//   spans 0..DATA_WIDTH-1 and both 0 and -1 give DATA_WIDTH-1.
// Ports:
//   sample  in   signed [DATA_WIDTH-1:0]  sample to inspect
//   rsb     out  [SHIFT_W-1:0]            redundant sign bits
module cbfp_rsb_cnt
  import cbfp_pkg::*;
#(
  parameter int  DATA_WIDTH = 5,
  localparam int SHIFT_W    = shift_width(DATA_WIDTH)
) (
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic        [SHIFT_W-1:0]    rsb
);

  // Walk down from the bit just below the MSB; stop at the first bit that
  // differs from the sign.
  always_comb begin
    int   run;
    logic stop;
    run  = 0;
    stop = 1'b0;
    for (int b = DATA_WIDTH - 2; b >= 0; b--) begin
      if (!stop && (sample[b] == sample[DATA_WIDTH-1])) begin
        run = run + 1;
      end else begin
        stop = 1'b1;
      end
    end
    rsb = SHIFT_W'(run);
  end

endmodule

// File: rtl/cbfp_blk_window.sv
// cbfp_blk_window
//   Collects REG_DEPTH valid beats of LANES complex samples into one block
//   and computes the block's common normalization shift (minimum redundant
//   sign bits over every I and Q sample of the block). On completion the
//   block and its shift are presented together for one cycle.
//
//   Optional feature (macro CBFP_BLK_CNT_EN): adds a 16-bit wrapping block
//   counter output blk_idx, updated on the completing edge, cleared by clr.
//
// Ports:
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   clr        in   synchronous block restart (window data kept)
//   din_valid  in   beat qualifier
//   din_i/q    in   LANES signed input samples
//   dout_i/q   out  window per lane, index 0 newest
//   blk_valid  out  one-cycle pulse, block complete
//   blk_shift  out  block normalization shift, held until next block
//   fill_cnt   out  beats held in the current block
//   blk_idx    out  (CBFP_BLK_CNT_EN only) completed-block count
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no beats of the current block held, fill_cnt 0
//   ST_FILL  | 1..REG_DEPTH-1 beats of the current block held
module cbfp_blk_window
  import cbfp_pkg::*;
#(
  parameter int  DATA_WIDTH = 5,
  parameter int  REG_DEPTH  = 4,
  parameter int  LANES      = 2,
  parameter int  SHIFT_W    = shift_width(DATA_WIDTH),
  localparam int CNT_W      = cnt_width(REG_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clr,
  input  logic                         din_valid,
  input  logic signed [DATA_WIDTH-1:0] din_i  [0:LANES-1],
  input  logic signed [DATA_WIDTH-1:0] din_q  [0:LANES-1],
  output logic signed [DATA_WIDTH-1:0] dout_i [0:LANES-1][0:REG_DEPTH-1],
  output logic signed [DATA_WIDTH-1:0] dout_q [0:LANES-1][0:REG_DEPTH-1],
  output logic                         blk_valid,
  output logic        [SHIFT_W-1:0]    blk_shift,
  output logic        [CNT_W-1:0]      fill_cnt
`ifdef CBFP_BLK_CNT_EN
  ,
  output logic        [15:0]           blk_idx
`endif
);

  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(shift_max(DATA_WIDTH));
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(REG_DEPTH - 1);

  logic [SHIFT_W-1:0] rsb_i [0:LANES-1];
  logic [SHIFT_W-1:0] rsb_q [0:LANES-1];
  logic [SHIFT_W-1:0] bm;
  logic [SHIFT_W-1:0] run_min;
  logic [SHIFT_W-1:0] run_min_nxt;
  logic               last_beat;
  state_t             state;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    cbfp_rsb_cnt #(.DATA_WIDTH(DATA_WIDTH)) u_rsb_i (
      .sample (din_i[l]),
      .rsb    (rsb_i[l])
    );
    cbfp_rsb_cnt #(.DATA_WIDTH(DATA_WIDTH)) u_rsb_q (
      .sample (din_q[l]),
      .rsb    (rsb_q[l])
    );
  end

  // Beat metric: smallest headroom over all lanes and both components.
  always_comb begin
    bm = SHIFT_MAX;
    for (int l = 0; l < LANES; l++) begin
      if (rsb_i[l] < bm) bm = rsb_i[l];
      if (rsb_q[l] < bm) bm = rsb_q[l];
    end
  end

  assign run_min_nxt = (bm < run_min) ? bm : run_min;

  // Only reachable from FILL because a block always has at least two beats.
  assign last_beat = din_valid && (state == ST_FILL) && (fill_cnt == LAST_CNT);

  // Window shift register; clr deliberately leaves the data alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < REG_DEPTH; k++) begin
          dout_i[l][k] <= '0;
          dout_q[l][k] <= '0;
        end
      end
    end else if (din_valid) begin
      for (int l = 0; l < LANES; l++) begin
        dout_i[l][0] <= din_i[l];
        dout_q[l][0] <= din_q[l];
        for (int k = 1; k < REG_DEPTH; k++) begin
          dout_i[l][k] <= dout_i[l][k-1];
          dout_q[l][k] <= dout_q[l][k-1];
        end
      end
    end
  end

  // Block-collection FSM with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_EMPTY;
      fill_cnt  <= '0;
      run_min   <= SHIFT_MAX;
      blk_valid <= 1'b0;
      blk_shift <= '0;
`ifdef CBFP_BLK_CNT_EN
      blk_idx   <= '0;
`endif
    end else begin
      blk_valid <= 1'b0;
      if (clr) begin
        // A beat arriving with clr becomes beat 1 of a fresh block; clr also
        // suppresses a completion that would otherwise happen on this edge.
        state    <= din_valid ? ST_FILL : ST_EMPTY;
        fill_cnt <= din_valid ? CNT_W'(1) : '0;
        run_min  <= din_valid ? bm : SHIFT_MAX;
`ifdef CBFP_BLK_CNT_EN
        blk_idx  <= '0;
`endif
      end else if (din_valid) begin
        case (state)
          ST_EMPTY: begin
            state    <= ST_FILL;
            fill_cnt <= CNT_W'(1);
            run_min  <= run_min_nxt;
          end
          ST_FILL: begin
            if (last_beat) begin
              state     <= ST_EMPTY;
              fill_cnt  <= '0;
              run_min   <= SHIFT_MAX;
              blk_valid <= 1'b1;
              blk_shift <= run_min_nxt;
`ifdef CBFP_BLK_CNT_EN
              blk_idx   <= blk_idx + 16'd1;
`endif
            end else begin
              fill_cnt <= fill_cnt + CNT_W'(1);
              run_min  <= run_min_nxt;
            end
          end
          default: begin
            state    <= ST_EMPTY;
            fill_cnt <= '0;
            run_min  <= SHIFT_MAX;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cbfp_blk_window.sv
module tb_cbfp_blk_window;

  localparam int DW = 5;
  localparam int D  = 4;
  localparam int L  = 2;
  localparam int SW = 3;
  localparam int CW = 3;
  localparam int PW = L * D * 2 * DW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic din_valid = 1'b0;
  logic signed [DW-1:0] din_i  [0:L-1];
  logic signed [DW-1:0] din_q  [0:L-1];
  logic signed [DW-1:0] dout_i [0:L-1][0:D-1];
  logic signed [DW-1:0] dout_q [0:L-1][0:D-1];
  logic                 blk_valid;
  logic [SW-1:0]        blk_shift;
  logic [CW-1:0]        fill_cnt;
`ifdef CBFP_BLK_CNT_EN
  logic [15:0]          blk_idx;
`endif

  cbfp_blk_window #(.DATA_WIDTH(DW), .REG_DEPTH(D), .LANES(L)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .din_valid (din_valid),
    .din_i     (din_i),
    .din_q     (din_q),
    .dout_i    (dout_i),
    .dout_q    (dout_q),
    .blk_valid (blk_valid),
    .blk_shift (blk_shift),
    .fill_cnt  (fill_cnt)
`ifdef CBFP_BLK_CNT_EN
    ,
    .blk_idx   (blk_idx)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic signed [DW-1:0] mw_i [0:L-1][0:D-1];
  logic signed [DW-1:0] mw_q [0:L-1][0:D-1];
  int   m_fill, m_min, m_shift, m_idx;
  logic m_bv;

  typedef struct packed {
    logic [SW-1:0] shift;
    logic [PW-1:0] data;
  } blk_t;
  blk_t sb_q[$];

  // Headroom via significant-bit length of the magnitude-like value.
  function automatic int rsb_m(input logic signed [DW-1:0] x);
    logic [DW-1:0] y;
    int bl;
    y  = x[DW-1] ? ~x : x;
    bl = 0;
    for (int b = 0; b < DW; b++) if (y[b]) bl = b + 1;
    return (DW - 1) - bl;
  endfunction

  function automatic logic [PW-1:0] pack_model();
    logic [PW-1:0] r;
    r = '0;
    for (int l = 0; l < L; l++)
      for (int k = 0; k < D; k++) begin
        r[(l*D+k)*2*DW +: DW]      = mw_i[l][k];
        r[(l*D+k)*2*DW + DW +: DW] = mw_q[l][k];
      end
    return r;
  endfunction

  function automatic logic [PW-1:0] pack_dut();
    logic [PW-1:0] r;
    r = '0;
    for (int l = 0; l < L; l++)
      for (int k = 0; k < D; k++) begin
        r[(l*D+k)*2*DW +: DW]      = dout_i[l][k];
        r[(l*D+k)*2*DW + DW +: DW] = dout_q[l][k];
      end
    return r;
  endfunction

  task automatic reset_model();
    for (int l = 0; l < L; l++)
      for (int k = 0; k < D; k++) begin
        mw_i[l][k] = '0;
        mw_q[l][k] = '0;
      end
    m_fill = 0; m_min = DW - 1; m_shift = 0; m_idx = 0; m_bv = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus and advance the model across the edge.
  task automatic step(input logic v, input logic c, input int i0, input int q0,
                      input int i1, input int q1);
    int   bm;
    logic done;
    din_valid = v; clr = c;
    din_i[0] = DW'(i0); din_q[0] = DW'(q0);
    din_i[1] = DW'(i1); din_q[1] = DW'(q1);
    bm = DW - 1;
    for (int l = 0; l < L; l++) begin
      if (rsb_m(din_i[l]) < bm) bm = rsb_m(din_i[l]);
      if (rsb_m(din_q[l]) < bm) bm = rsb_m(din_q[l]);
    end
    @(posedge clk);
    done = 1'b0;
    if (v) begin
      for (int l = 0; l < L; l++) begin
        for (int k = D - 1; k > 0; k--) begin
          mw_i[l][k] = mw_i[l][k-1];
          mw_q[l][k] = mw_q[l][k-1];
        end
        mw_i[l][0] = din_i[l];
        mw_q[l][0] = din_q[l];
      end
    end
    if (c) begin
      m_fill = v ? 1 : 0;
      m_min  = v ? bm : DW - 1;
      m_idx  = 0;
    end else if (v) begin
      if (bm < m_min) m_min = bm;
      m_fill++;
      if (m_fill == D) begin
        done    = 1'b1;
        m_shift = m_min;
        m_fill  = 0;
        m_min   = DW - 1;
        m_idx   = (m_idx + 1) & 16'hffff;
        sb_q.push_back({SW'(m_shift), pack_model()});
      end
    end
    m_bv = done;
    #1;
  endtask

  // Scoreboard / per-cycle comparator, sampled mid-cycle.
  always @(negedge clk) begin
    blk_t e;
    blk_t a;
    if (rstn === 1'b1) begin
      checks++;
      if (fill_cnt !== CW'(m_fill)) begin
        errors++;
        $display("FAIL fill_cnt: got %0d expected %0d at %0t", fill_cnt, m_fill, $time);
      end
      checks++;
      if (blk_valid !== m_bv) begin
        errors++;
        $display("FAIL blk_valid: got %b expected %b at %0t", blk_valid, m_bv, $time);
      end
      checks++;
      if (blk_shift !== SW'(m_shift)) begin
        errors++;
        $display("FAIL blk_shift: got %0d expected %0d at %0t", blk_shift, m_shift, $time);
      end
      checks++;
      if (pack_dut() !== pack_model()) begin
        errors++;
        $display("FAIL window: got %h expected %h at %0t", pack_dut(), pack_model(), $time);
      end
`ifdef CBFP_BLK_CNT_EN
      checks++;
      if (blk_idx !== 16'(m_idx)) begin
        errors++;
        $display("FAIL blk_idx: got %0d expected %0d at %0t", blk_idx, m_idx, $time);
      end
`endif
      if (blk_valid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL blk_unexpected: got blk_valid=1 expected no pending block at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          a.shift = blk_shift;
          a.data  = pack_dut();
          if (a !== e) begin
            errors++;
            $display("FAIL blk_content: got %h expected %h at %0t", a, e, $time);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0; clr = 1'b0; din_valid = 1'b0;
    for (int l = 0; l < L; l++) begin din_i[l] = '0; din_q[l] = '0; end
    reset_model();
    #22;
    checks++;
    if (blk_valid !== 1'b0 || blk_shift !== '0 || fill_cnt !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b shift=%0d fill=%0d expected 0 0 0",
               blk_valid, blk_shift, fill_cnt);
    end
    checks++;
    if (pack_dut() !== '0) begin
      errors++;
      $display("FAIL reset_window: got %h expected 0", pack_dut());
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] exp_w [0:D-1];
    exp_w[0] = 5'sd0; exp_w[1] = -5'sd4; exp_w[2] = 5'sd3; exp_w[3] = 5'sd1;
    step(1, 0,  1, 0, 0, 0);
    step(1, 0,  3, 0, 0, 0);
    step(1, 0, -4, 0, 0, 0);
    step(1, 0,  0, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b1 || blk_shift !== 3'd2 || fill_cnt !== 3'd0) begin
      errors++;
      $display("FAIL basic_block: got valid=%b shift=%0d fill=%0d expected 1 2 0",
               blk_valid, blk_shift, fill_cnt);
    end
    for (int k = 0; k < D; k++) begin
      checks++;
      if (dout_i[0][k] !== exp_w[k]) begin
        errors++;
        $display("FAIL basic_dout_i%0d: got %0d expected %0d", k, dout_i[0][k], exp_w[k]);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: got %b expected 0", blk_valid);
    end
    step(1, 0,  1, 0, 0, 0);
    step(1, 0,  3, 15, 0, 0);
    step(1, 0, -4, 0, 0, 0);
    step(1, 0,  0, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b1 || blk_shift !== 3'd0) begin
      errors++;
      $display("FAIL q15_block: got valid=%b shift=%0d expected 1 0", blk_valid, blk_shift);
    end
  endtask

  task automatic test_gaps();
    step(1, 0, 5, -3, 2, 1);
    step(0, 0, 9, 9, 9, 9);
    step(0, 0, 9, 9, 9, 9);
    checks++;
    if (blk_valid !== 1'b0 || fill_cnt !== 3'd1 || dout_i[0][0] !== 5'sd5) begin
      errors++;
      $display("FAIL gap_hold: got valid=%b fill=%0d d0=%0d expected 0 1 5",
               blk_valid, fill_cnt, dout_i[0][0]);
    end
    step(1, 0, 1, 1, -2, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_early: got %b expected 0", blk_valid);
    end
    step(1, 0, 7, 0, 0, -1);
    checks++;
    if (blk_valid !== 1'b1 || blk_shift !== 3'd1) begin
      errors++;
      $display("FAIL gap_block: got valid=%b shift=%0d expected 1 1", blk_valid, blk_shift);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 1, 15, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b1 || blk_shift !== 3'd0) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b shift=%0d expected 1 0", blk_valid, blk_shift);
    end
    step(1, 0, 1, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b0 || fill_cnt !== 3'd1) begin
      errors++;
      $display("FAIL b2b_restart: got valid=%b fill=%0d expected 0 1", blk_valid, fill_cnt);
    end
    step(1, 0, 2, 0, 0, 0);
    step(1, 0, -1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b1 || blk_shift !== 3'd2) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b shift=%0d expected 1 2", blk_valid, blk_shift);
    end
  endtask

  task automatic test_clr();
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 2, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0);
    checks++;
    if (fill_cnt !== 3'd1) begin
      errors++;
      $display("FAIL clr_beat: got fill=%0d expected 1", fill_cnt);
    end
    step(1, 0, 4, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b0 || fill_cnt !== 3'd2) begin
      errors++;
      $display("FAIL clr_no_blk: got valid=%b fill=%0d expected 0 2", blk_valid, fill_cnt);
    end
    step(1, 0, 5, 0, 0, 0);
    step(1, 0, 6, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_blk6: got %b expected 1", blk_valid);
    end
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b0 || fill_cnt !== 3'd1) begin
      errors++;
      $display("FAIL clr_on_last: got valid=%b fill=%0d expected 0 1", blk_valid, fill_cnt);
    end
    step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_mid_reset();
    step(1, 0, 3, -7, 2, 2);
    step(1, 0, 1, 1, 1, 1);
    step(1, 0, -9, 4, 0, 0);
    checks++;
    if (fill_cnt !== 3'd3) begin
      errors++;
      $display("FAIL mid_fill: got %0d expected 3", fill_cnt);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (blk_valid !== 1'b0 || blk_shift !== '0 || fill_cnt !== '0 || pack_dut() !== '0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b shift=%0d fill=%0d win=%h expected all 0",
               blk_valid, blk_shift, fill_cnt, pack_dut());
    end
    reset_model();
    rstn = 1'b1;
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 3, 0, 0, 0);
    step(1, 0, -4, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (blk_valid !== 1'b1 || blk_shift !== 3'd2) begin
      errors++;
      $display("FAIL post_reset_blk: got valid=%b shift=%0d expected 1 2", blk_valid, blk_shift);
    end
`ifdef CBFP_BLK_CNT_EN
    checks++;
    if (blk_idx !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_idx: got %0d expected 1", blk_idx);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31));
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_clr();
    test_mid_reset();
    test_random();
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL blk_missing: got %0d unmatched blocks expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
